// File: rtl/bus_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and the shared data-memory bus.
// The arbiter uses the slave view; the requesters and bus use the master view.
interface bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            m0_req;
    logic            m0_we;
    logic [AW-1:0]   m0_addr;
    logic [DW/8-1:0] m0_wstrb;
    logic [DW-1:0]   m0_wdata;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;

    logic            m1_req;
    logic            m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW/8-1:0] m1_wstrb;
    logic [DW-1:0]   m1_wdata;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;

    logic [AW-1:0]   bus_addr;
    logic            bus_re;
    logic            bus_we;
    logic [DW/8-1:0] bus_wstrb;
    logic [DW-1:0]   bus_wdata;
    logic [DW-1:0]   bus_rdata;

    // Handshake: a requester holds req and stable fields until its one-cycle gnt;
    // read data comes back on a one-cycle rvalid, RD_LAT cycles after the grant.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wstrb, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wstrb, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output bus_addr, bus_re, bus_we, bus_wstrb, bus_wdata,
        input  bus_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wstrb, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wstrb, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  bus_addr, bus_re, bus_we, bus_wstrb, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory bus between two masters,
// issuing one access per grant and steering read data back to the issuing master.
module bus_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.slave   bif,
    output logic           busy
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            resp;
    logic            arb_en;
    logic            grant;
    logic            win;
    logic            win_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        resp   = (state_q == WAIT) && (cnt_q == CW'(1));
        // rst gating keeps grants and bus strobes quiet while reset is held
        arb_en = rst && ((state_q == IDLE) || resp);
        grant  = arb_en && (bif.m0_req || bif.m1_req);
        win    = (bif.m0_req && bif.m1_req) ? ~last_q : bif.m1_req;
        win_we = win ? bif.m1_we : bif.m0_we;

        bif.m0_gnt    = grant && !win;
        bif.m1_gnt    = grant && win;
        bif.bus_addr  = '0;
        bif.bus_wstrb = '0;
        bif.bus_wdata = '0;
        bif.bus_re    = 1'b0;
        bif.bus_we    = 1'b0;
        if (grant) begin
            bif.bus_addr  = win ? bif.m1_addr  : bif.m0_addr;
            bif.bus_wstrb = win ? bif.m1_wstrb : bif.m0_wstrb;
            bif.bus_wdata = win ? bif.m1_wdata : bif.m0_wdata;
            bif.bus_re    = !win_we;
            bif.bus_we    = win_we;
        end

        bif.m0_rvalid = resp && !owner_q;
        bif.m1_rvalid = resp && owner_q;
        bif.m0_rdata  = bif.m0_rvalid ? bif.bus_rdata : '0;
        bif.m1_rdata  = bif.m1_rvalid ? bif.bus_rdata : '0;

        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (state_q == WAIT) begin
            cnt_d = cnt_q - CW'(1);
            if (resp) begin
                state_d = IDLE;
            end
        end
        // a read granted on the response cycle re-arms the wait immediately
        if (grant) begin
            last_d = win;
            if (!win_we) begin
                state_d = WAIT;
                owner_d = win;
                cnt_d   = CW'(RD_LAT);
            end
        end
    end

    assign busy = (state_q == WAIT);
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (RD_LAT 1, 2, 3) with a fixed-latency memory model.
module tb_bus_arbiter;
    logic clk;
    logic rst;
    logic busy1, busy2, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp_v;

    bus_arbiter_if #(.AW(32), .DW(32)) if1 ();
    bus_arbiter_if #(.AW(32), .DW(32)) if2 ();
    bus_arbiter_if #(.AW(32), .DW(32)) if3 ();

    bus_arbiter #(.RD_LAT(1), .AW(32), .DW(32)) u1 (.clk(clk), .rst(rst), .bif(if1), .busy(busy1));
    bus_arbiter #(.RD_LAT(2), .AW(32), .DW(32)) u2 (.clk(clk), .rst(rst), .bif(if2), .busy(busy2));
    bus_arbiter #(.RD_LAT(3), .AW(32), .DW(32)) u3 (.clk(clk), .rst(rst), .bif(if3), .busy(busy3));

    // {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_re, bus_we, busy}
    logic [6:0] ctl1, ctl2, ctl3;
    assign ctl1 = {if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid, if1.bus_re, if1.bus_we, busy1};
    assign ctl2 = {if2.m0_gnt, if2.m1_gnt, if2.m0_rvalid, if2.m1_rvalid, if2.bus_re, if2.bus_we, busy2};
    assign ctl3 = {if3.m0_gnt, if3.m1_gnt, if3.m0_rvalid, if3.m1_rvalid, if3.bus_re, if3.bus_we, busy3};

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // memory model: data for the address on the bus appears RD_LAT cycles later
    logic [31:0] p1 = '0;
    logic [31:0] p2 [2] = '{default: '0};
    logic [31:0] p3 [3] = '{default: '0};
    always @(posedge clk) begin
        p1    <= if1.bus_addr;
        p2[0] <= if2.bus_addr;
        p2[1] <= p2[0];
        p3[0] <= if3.bus_addr;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.bus_rdata = mem_fn(p1);
    assign if2.bus_rdata = mem_fn(p2[1]);
    assign if3.bus_rdata = mem_fn(p3[2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if1.m0_req = 0; if1.m0_we = 0; if1.m0_addr = '0; if1.m0_wstrb = '0; if1.m0_wdata = '0;
        if1.m1_req = 0; if1.m1_we = 0; if1.m1_addr = '0; if1.m1_wstrb = '0; if1.m1_wdata = '0;
        if2.m0_req = 0; if2.m0_we = 0; if2.m0_addr = '0; if2.m0_wstrb = '0; if2.m0_wdata = '0;
        if2.m1_req = 0; if2.m1_we = 0; if2.m1_addr = '0; if2.m1_wstrb = '0; if2.m1_wdata = '0;
        if3.m0_req = 0; if3.m0_we = 0; if3.m0_addr = '0; if3.m0_wstrb = '0; if3.m0_wdata = '0;
        if3.m1_req = 0; if3.m1_we = 0; if3.m1_addr = '0; if3.m1_wstrb = '0; if3.m1_wdata = '0;
    endtask

    task automatic apply_reset();
        rst = 0;
        cyc();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        if1.m0_req = 1; if1.m0_we = 1; if1.m0_addr = 32'h10; if1.m0_wdata = 32'h1234; if1.m0_wstrb = 4'hF;
        if1.m1_req = 1; if1.m1_we = 0; if1.m1_addr = 32'h20;
        #2;
        if (ctl1 !== 7'b0 || ctl2 !== 7'b0 || ctl3 !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctl got=%b/%b/%b exp=0", ctl1, ctl2, ctl3);
        end
        n_checks++;
        if (if1.bus_addr !== 32'h0 || if1.bus_wdata !== 32'h0 || if1.bus_wstrb !== 4'h0) begin
            n_fail++; $display("FAIL reset_bus got addr=%h wdata=%h wstrb=%h exp=0", if1.bus_addr, if1.bus_wdata, if1.bus_wstrb);
        end
        n_checks++;
        if (if1.m0_rdata !== 32'h0 || if1.m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0", if1.m0_rdata, if1.m1_rdata);
        end
        n_checks++;
        cyc();
        cyc();
        idle_all();
        rst = 1;
        #1;
        if (ctl1 !== 7'b0) begin
            n_fail++; $display("FAIL post_reset_idle got=%b exp=0", ctl1);
        end
        n_checks++;
        cyc();
    endtask

    task automatic test_single_read();
        if1.m0_req = 1; if1.m0_we = 0; if1.m0_addr = 32'h100;
        #1;
        if (ctl1 !== 7'b1000100 || if1.bus_addr !== 32'h100) begin
            n_fail++; $display("FAIL rd_issue got ctl=%b addr=%h exp ctl=1000100 addr=100", ctl1, if1.bus_addr);
        end
        n_checks++;
        exp_q.push_back(32'hDEADBEEF);
        cyc();
        if1.m0_req = 0;
        #1;
        if (ctl1 !== 7'b0010001) begin
            n_fail++; $display("FAIL rd_resp_ctl got=%b exp=0010001", ctl1);
        end
        n_checks++;
        exp_v = exp_q.pop_front();
        if (if1.m0_rdata !== exp_v || if1.m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rd_data got=%h m1=%h exp=%h m1=0", if1.m0_rdata, if1.m1_rdata, exp_v);
        end
        n_checks++;
        cyc();
        if (ctl1 !== 7'b0) begin
            n_fail++; $display("FAIL rd_done got=%b exp=0", ctl1);
        end
        n_checks++;
    endtask

    task automatic test_alternate_writes();
        apply_reset();
        if1.m0_req = 1; if1.m0_we = 1; if1.m0_addr = 32'h10; if1.m0_wdata = 32'h1111_0000; if1.m0_wstrb = 4'hF;
        if1.m1_req = 1; if1.m1_we = 1; if1.m1_addr = 32'h20; if1.m1_wdata = 32'h2222_0000; if1.m1_wstrb = 4'h3;
        for (int i = 0; i < 4; i++) exp_q.push_back((i % 2) ? 32'h20 : 32'h10);
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_v = exp_q.pop_front();
            if (if1.bus_addr !== exp_v) begin
                n_fail++; $display("FAIL alt_addr[%0d] got=%h exp=%h", i, if1.bus_addr, exp_v);
            end
            n_checks++;
            if (ctl1 !== ((i % 2) ? 7'b0100010 : 7'b1000010)) begin
                n_fail++; $display("FAIL alt_ctl[%0d] got=%b exp=%b", i, ctl1, ((i % 2) ? 7'b0100010 : 7'b1000010));
            end
            n_checks++;
            if (if1.bus_wdata !== ((i % 2) ? 32'h2222_0000 : 32'h1111_0000) ||
                if1.bus_wstrb !== ((i % 2) ? 4'h3 : 4'hF)) begin
                n_fail++; $display("FAIL alt_wdata[%0d] got=%h strb=%h", i, if1.bus_wdata, if1.bus_wstrb);
            end
            n_checks++;
            cyc();
        end
        if1.m0_req = 0; if1.m1_req = 0;
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            if1.m0_req = 1; if1.m0_we = 0; if1.m0_addr = 32'(4 * i);
            #1;
            if (ctl1 !== ((i > 0) ? 7'b1010101 : 7'b1000100)) begin
                n_fail++; $display("FAIL b2b_ctl[%0d] got=%b exp=%b", i, ctl1, ((i > 0) ? 7'b1010101 : 7'b1000100));
            end
            n_checks++;
            if (i > 0) begin
                exp_v = exp_q.pop_front();
                if (if1.m0_rdata !== exp_v) begin
                    n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i - 1, if1.m0_rdata, exp_v);
                end
                n_checks++;
            end
            exp_q.push_back(mem_fn(32'(4 * i)));
            cyc();
        end
        if1.m0_req = 0;
        #1;
        if (ctl1 !== 7'b0010001) begin
            n_fail++; $display("FAIL b2b_last_ctl got=%b exp=0010001", ctl1);
        end
        n_checks++;
        exp_v = exp_q.pop_front();
        if (if1.m0_rdata !== exp_v) begin
            n_fail++; $display("FAIL b2b_data[2] got=%h exp=%h", if1.m0_rdata, exp_v);
        end
        n_checks++;
        cyc();
        if (ctl1 !== 7'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_done got=%b pending=%0d exp=0/0", ctl1, exp_q.size());
        end
        n_checks++;
    endtask

    task automatic test_zero_strobe();
        if1.m1_req = 1; if1.m1_we = 1; if1.m1_addr = 32'h30; if1.m1_wstrb = 4'h0; if1.m1_wdata = 32'hCAFE;
        #1;
        if (ctl1 !== 7'b0100010 || if1.bus_wstrb !== 4'h0 || if1.bus_addr !== 32'h30) begin
            n_fail++; $display("FAIL zero_strobe got ctl=%b strb=%h addr=%h exp 0100010/0/30", ctl1, if1.bus_wstrb, if1.bus_addr);
        end
        n_checks++;
        cyc();
        if1.m1_req = 0;
    endtask

    task automatic test_wait_pending();
        apply_reset();
        if3.m1_req = 1; if3.m1_we = 0; if3.m1_addr = 32'h40;
        #1;
        if (ctl3 !== 7'b0100100 || if3.bus_addr !== 32'h40) begin
            n_fail++; $display("FAIL wp_issue got ctl=%b addr=%h exp 0100100/40", ctl3, if3.bus_addr);
        end
        n_checks++;
        exp_q.push_back(mem_fn(32'h40));
        cyc();
        if3.m1_req = 0;
        if3.m0_req = 1; if3.m0_we = 1; if3.m0_addr = 32'h80; if3.m0_wdata = 32'h8080_8080; if3.m0_wstrb = 4'hF;
        for (int k = 1; k < 3; k++) begin
            #1;
            if (ctl3 !== 7'b0000001 || if3.bus_addr !== 32'h0) begin
                n_fail++; $display("FAIL wp_hold[T+%0d] got ctl=%b addr=%h exp 0000001/0", k, ctl3, if3.bus_addr);
            end
            n_checks++;
            cyc();
        end
        #1;
        if (ctl3 !== 7'b1001011 || if3.bus_addr !== 32'h80 || if3.bus_wdata !== 32'h8080_8080) begin
            n_fail++; $display("FAIL wp_resp got ctl=%b addr=%h wdata=%h exp 1001011/80/80808080", ctl3, if3.bus_addr, if3.bus_wdata);
        end
        n_checks++;
        exp_v = exp_q.pop_front();
        if (if3.m1_rdata !== exp_v || if3.m0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wp_data got=%h m0=%h exp=%h m0=0", if3.m1_rdata, if3.m0_rdata, exp_v);
        end
        n_checks++;
        cyc();
        if3.m0_req = 0;
        #1;
        if (ctl3 !== 7'b0) begin
            n_fail++; $display("FAIL wp_done got=%b exp=0", ctl3);
        end
        n_checks++;
    endtask

    task automatic test_reset_in_wait();
        if2.m0_req = 1; if2.m0_we = 0; if2.m0_addr = 32'h200;
        #1;
        if (ctl2 !== 7'b1000100) begin
            n_fail++; $display("FAIL rw_issue got=%b exp=1000100", ctl2);
        end
        n_checks++;
        cyc();
        if2.m0_req = 0;
        #1;
        if (ctl2 !== 7'b0000001) begin
            n_fail++; $display("FAIL rw_wait got=%b exp=0000001", ctl2);
        end
        n_checks++;
        rst = 0;
        #1;
        if (ctl2 !== 7'b0 || if2.bus_addr !== 32'h0 || if2.m0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rw_in_reset got ctl=%b addr=%h rdata=%h exp 0", ctl2, if2.bus_addr, if2.m0_rdata);
        end
        n_checks++;
        cyc();
        rst = 1;
        if2.m0_req = 1; if2.m0_we = 1; if2.m0_addr = 32'h10; if2.m0_wdata = 32'hA; if2.m0_wstrb = 4'hF;
        if2.m1_req = 1; if2.m1_we = 1; if2.m1_addr = 32'h20; if2.m1_wdata = 32'hB; if2.m1_wstrb = 4'hF;
        #1;
        if (ctl2 !== 7'b1000010 || if2.m0_rdata !== 32'h0 || if2.bus_addr !== 32'h10) begin
            n_fail++; $display("FAIL rw_release got ctl=%b rdata=%h addr=%h exp 1000010/0/10", ctl2, if2.m0_rdata, if2.bus_addr);
        end
        n_checks++;
        cyc();
        if2.m0_req = 0; if2.m1_req = 0;
        #1;
        if (ctl2 !== 7'b0) begin
            n_fail++; $display("FAIL rw_done got=%b exp=0", ctl2);
        end
        n_checks++;
        cyc();
    endtask

    task automatic test_withdraw();
        if2.m0_req = 1; if2.m0_we = 0; if2.m0_addr = 32'h300;
        #1;
        if (ctl2 !== 7'b1000100) begin
            n_fail++; $display("FAIL wd_issue got=%b exp=1000100", ctl2);
        end
        n_checks++;
        exp_q.push_back(mem_fn(32'h300));
        cyc();
        if2.m0_req = 0;
        if2.m1_req = 1; if2.m1_we = 1; if2.m1_addr = 32'h44; if2.m1_wdata = 32'h44; if2.m1_wstrb = 4'hF;
        #1;
        if (ctl2 !== 7'b0000001 || if2.bus_addr !== 32'h0) begin
            n_fail++; $display("FAIL wd_pulse got ctl=%b addr=%h exp 0000001/0", ctl2, if2.bus_addr);
        end
        n_checks++;
        cyc();
        if2.m1_req = 0;
        #1;
        if (ctl2 !== 7'b0010001) begin
            n_fail++; $display("FAIL wd_resp got=%b exp=0010001", ctl2);
        end
        n_checks++;
        exp_v = exp_q.pop_front();
        if (if2.m0_rdata !== exp_v || if2.m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wd_data got=%h m1=%h exp=%h m1=0", if2.m0_rdata, if2.m1_rdata, exp_v);
        end
        n_checks++;
        cyc();
        if (ctl2 !== 7'b0) begin
            n_fail++; $display("FAIL wd_done got=%b exp=0", ctl2);
        end
        n_checks++;
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_alternate_writes();
        test_back_to_back();
        test_zero_strobe();
        test_wait_pending();
        test_reset_in_wait();
        test_withdraw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
